// File: rtl/exec_seq_pkg.sv
// Shared encodings, FSM states and decode helpers for the exec_sequencer.
package exec_seq_pkg;

  localparam logic [6:0] OP_R = 7'b0000001;
  localparam logic [6:0] OP_I = 7'b0000011;
  localparam logic [6:0] OP_U = 7'b0000111;
  localparam logic [6:0] OP_B = 7'b0001111;

  // One bit per funct code: bit n set means funct n is legal for that opcode.
  localparam logic [15:0] FUNCT_MASK_R = 16'h21F3;
  localparam logic [15:0] FUNCT_MASK_I = 16'h00F3;
  localparam logic [15:0] FUNCT_MASK_B = 16'h00FB;

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    DECODE,
    EXEC,
    WB,
    HALT
  } state_t;

  function automatic logic [6:0] f_opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [3:0] f_funct(input logic [31:0] instr);
    return instr[15:12];
  endfunction

  function automatic logic [4:0] f_rs1(input logic [31:0] instr);
    return instr[20:16];
  endfunction

  function automatic logic [4:0] f_rs2(input logic [31:0] instr);
    return instr[25:21];
  endfunction

  function automatic logic [31:0] imm_i(input logic [31:0] instr);
    return {{21{instr[31]}}, instr[31:21]};
  endfunction

  function automatic logic [31:0] imm_u(input logic [31:0] instr);
    return {{12{instr[31]}}, instr[31:12]};
  endfunction

  function automatic logic [31:0] imm_b(input logic [31:0] instr);
    return {{21{instr[31]}}, instr[31:26], instr[11:7]};
  endfunction

  function automatic logic [31:0] imm_sel(input logic [31:0] instr);
    logic [31:0] imm;
    case (f_opcode(instr))
      OP_I:    imm = imm_i(instr);
      OP_U:    imm = imm_u(instr);
      OP_B:    imm = imm_b(instr);
      default: imm = 32'd0;
    endcase
    return imm;
  endfunction

  function automatic logic is_legal(input logic [6:0] opcode, input logic [3:0] funct);
    logic legal;
    case (opcode)
      OP_R:    legal = FUNCT_MASK_R[funct];
      OP_I:    legal = FUNCT_MASK_I[funct];
      OP_B:    legal = FUNCT_MASK_B[funct];
      OP_U:    legal = 1'b1;
      default: legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/exec_seq_regfile.sv
// 32x32 register file: two asynchronous read ports, one synchronous write port.
// x0 always reads zero and ignores writes.
module exec_seq_regfile (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [4:0]  i_raddr1,
  input  logic [4:0]  i_raddr2,
  output logic [31:0] o_rdata1,
  output logic [31:0] o_rdata2,
  input  logic        i_we,
  input  logic [4:0]  i_waddr,
  input  logic [31:0] i_wdata
);

  logic [31:0] r_regs [32];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= 32'd0;
      end
    end else if (i_we && (i_waddr != 5'd0)) begin
      r_regs[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata1 = (i_raddr1 == 5'd0) ? 32'd0 : r_regs[i_raddr1];
  assign o_rdata2 = (i_raddr2 == 5'd0) ? 32'd0 : r_regs[i_raddr2];

endmodule

// File: rtl/exec_sequencer.sv
// Multicycle fetch/decode/execute/writeback sequencer owning the PC and register file.
// Define EXEC_SEQ_INSTRET_EN to implement the retired-instruction counter.
module exec_sequencer
  import exec_seq_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [6:0]  exu_opcode,
  output logic [3:0]  exu_funct,
  output logic [31:0] exu_imm,
  output logic [31:0] exu_rs1_data,
  output logic [31:0] exu_rs2_data,
  input  logic [31:0] exu_result,
  input  logic        exu_pc_update,
  input  logic        exu_we,
  input  logic        exu_err,
  output logic [31:0] pc,
  output logic        busy,
  output logic        halted,
  output logic        err,
  output logic [31:0] instret
);

  state_t      r_state;
  state_t      w_next_state;
  logic [31:0] r_pc;
  logic [31:0] r_ir;
  logic [6:0]  r_exu_opcode;
  logic [3:0]  r_exu_funct;
  logic [31:0] r_exu_imm;
  logic [31:0] r_op1;
  logic [31:0] r_op2;
  logic [31:0] r_result;
  logic        r_pc_upd;
  logic        r_we;
  logic        r_err;
  logic        w_legal;
  logic [31:0] w_rs1_data;
  logic [31:0] w_rs2_data;

  assign w_legal = is_legal(f_opcode(r_ir), f_funct(r_ir));

  exec_seq_regfile u_regfile (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_raddr1 (f_rs1(r_ir)),
    .i_raddr2 (f_rs2(r_ir)),
    .o_rdata1 (w_rs1_data),
    .o_rdata2 (w_rs2_data),
    .i_we     ((r_state == WB) && r_we),
    .i_waddr  (f_rd(r_ir)),
    .i_wdata  (r_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    imem_req     = 1'b0;
    busy         = 1'b1;
    halted       = 1'b0;
    case (r_state)
      IDLE: begin
        busy = 1'b0;
        if (start) w_next_state = FETCH;
      end
      FETCH: begin
        imem_req = 1'b1;
        if (imem_ack) w_next_state = DECODE;
      end
      DECODE:  w_next_state = w_legal ? EXEC : HALT;
      EXEC:    w_next_state = exu_err ? HALT : WB;
      WB:      w_next_state = FETCH;
      HALT: begin
        busy   = 1'b0;
        halted = 1'b1;
      end
      default: w_next_state = IDLE;
    endcase
  end

  // Execute-unit inputs load only for legal instructions so illegal functs never reach it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc         <= RESET_PC;
      r_ir         <= 32'd0;
      r_exu_opcode <= 7'd0;
      r_exu_funct  <= 4'd0;
      r_exu_imm    <= 32'd0;
      r_op1        <= 32'd0;
      r_op2        <= 32'd0;
      r_result     <= 32'd0;
      r_pc_upd     <= 1'b0;
      r_we         <= 1'b0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        FETCH: begin
          if (imem_ack) r_ir <= imem_rdata;
        end
        DECODE: begin
          if (w_legal) begin
            r_exu_opcode <= f_opcode(r_ir);
            r_exu_funct  <= f_funct(r_ir);
            r_exu_imm    <= imm_sel(r_ir);
            r_op1        <= w_rs1_data;
            r_op2        <= w_rs2_data;
          end else begin
            r_err <= 1'b1;
          end
        end
        EXEC: begin
          r_result <= exu_result;
          r_pc_upd <= exu_pc_update;
          r_we     <= exu_we;
          if (exu_err) r_err <= 1'b1;
        end
        WB: begin
          r_pc <= r_pc + (r_pc_upd ? r_result : 32'd4);
        end
        default: ;
      endcase
    end
  end

`ifdef EXEC_SEQ_INSTRET_EN
  logic [31:0] r_instret;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_instret <= 32'd0;
    end else if (r_state == WB) begin
      r_instret <= r_instret + 32'd1;
    end
  end

  assign instret = r_instret;
`else
  assign instret = 32'd0;
`endif

  assign imem_addr    = r_pc;
  assign pc           = r_pc;
  assign err          = r_err;
  assign exu_opcode   = r_exu_opcode;
  assign exu_funct    = r_exu_funct;
  assign exu_imm      = r_exu_imm;
  assign exu_rs1_data = r_op1;
  assign exu_rs2_data = r_op2;

endmodule

// File: tb/tb_exec_sequencer.sv
// Self-checking bench for exec_sequencer: behavioural execute unit, memory responder
// and an architectural reference model (regs/pc/instret) driving directed and random programs.
module tb_exec_sequencer;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] result;
    logic        pcUpd;
    logic        we;
    logic        err;
  } exuResp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic        imemReq;
  logic [31:0] imemAddr;
  logic        imemAck;
  logic [31:0] imemRdata;
  logic [6:0]  exuOpcode;
  logic [3:0]  exuFunct;
  logic [31:0] exuImm;
  logic [31:0] exuRs1Data;
  logic [31:0] exuRs2Data;
  logic [31:0] pc;
  logic        busy;
  logic        halted;
  logic        err;
  logic [31:0] instret;
  exuResp_t    exuResp;

  int          testsRun = 0;
  int          testsFailed = 0;
  logic [31:0] mRegs [32];
  logic [31:0] mPc;
  logic [31:0] mInstret;

  int rFns[8] = '{0, 1, 4, 5, 6, 7, 8, 13};
  int iFns[6] = '{0, 1, 4, 5, 6, 7};
  int bFns[6] = '{0, 1, 4, 5, 6, 7};

  // Execute unit semantics; funct 3 on a branch is a trap that raises err.
  function automatic exuResp_t exuBehave(input logic [6:0] op, input logic [3:0] fn,
                                         input logic [31:0] imm, input logic [31:0] a,
                                         input logic [31:0] b);
    exuResp_t r;
    r = '0;
    case (op)
      7'd1: begin
        r.we = 1'b1;
        case (fn)
          4'd0:    r.result = a + b;
          4'd1:    r.result = a - b;
          4'd4:    r.result = a ^ b;
          4'd5:    r.result = a | b;
          4'd6:    r.result = a & b;
          4'd7:    r.result = a << b[4:0];
          4'd8:    r.result = a >> b[4:0];
          4'd13:   r.result = 32'($signed(a) >>> b[4:0]);
          default: r.result = 32'd0;
        endcase
      end
      7'd3: begin
        r.we = 1'b1;
        case (fn)
          4'd0:    r.result = a + imm;
          4'd1:    r.result = a - imm;
          4'd4:    r.result = a ^ imm;
          4'd5:    r.result = a | imm;
          4'd6:    r.result = a & imm;
          4'd7:    r.result = a << imm[4:0];
          default: r.result = 32'd0;
        endcase
      end
      7'd7: begin
        r.we     = 1'b1;
        r.result = imm;
      end
      7'd15: begin
        r.result = imm;
        case (fn)
          4'd0:    r.pcUpd = (a == b);
          4'd1:    r.pcUpd = (a != b);
          4'd3:    r.err = 1'b1;
          4'd4:    r.pcUpd = ($signed(a) < $signed(b));
          4'd5:    r.pcUpd = ($signed(a) >= $signed(b));
          4'd6:    r.pcUpd = (a < b);
          4'd7:    r.pcUpd = (a >= b);
          default: r.err = 1'b1;
        endcase
      end
      default: r.err = 1'b1;
    endcase
    return r;
  endfunction

  always_comb exuResp = exuBehave(exuOpcode, exuFunct, exuImm, exuRs1Data, exuRs2Data);

  exec_sequencer #(.RESET_PC(RESET_PC)) dut (
    .clk           (clk),
    .rst           (rst),
    .start         (start),
    .imem_req      (imemReq),
    .imem_addr     (imemAddr),
    .imem_ack      (imemAck),
    .imem_rdata    (imemRdata),
    .exu_opcode    (exuOpcode),
    .exu_funct     (exuFunct),
    .exu_imm       (exuImm),
    .exu_rs1_data  (exuRs1Data),
    .exu_rs2_data  (exuRs2Data),
    .exu_result    (exuResp.result),
    .exu_pc_update (exuResp.pcUpd),
    .exu_we        (exuResp.we),
    .exu_err       (exuResp.err),
    .pc            (pc),
    .busy          (busy),
    .halted        (halted),
    .err           (err),
    .instret       (instret)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation exceeded its time budget");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    testsRun++;
    assert (observed === expected) else begin
      testsFailed++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expInstret();
`ifdef EXEC_SEQ_INSTRET_EN
    return mInstret;
`else
    return 32'd0;
`endif
  endfunction

  task automatic resetModel();
    for (int i = 0; i < 32; i++) mRegs[i] = 32'd0;
    mPc      = RESET_PC;
    mInstret = 32'd0;
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_pc"}, pc, RESET_PC);
    checkOutput({tag, "_req"}, 32'(imemReq), 32'd0);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_halted"}, 32'(halted), 32'd0);
    checkOutput({tag, "_err"}, 32'(err), 32'd0);
    checkOutput({tag, "_instret"}, instret, 32'd0);
    checkOutput({tag, "_exuImm"}, exuImm, 32'd0);
    checkOutput({tag, "_exuRs1"}, exuRs1Data, 32'd0);
  endtask

  task automatic checkHalt(input string tag);
    checkOutput({tag, "_halted"}, 32'(halted), 32'd1);
    checkOutput({tag, "_err"}, 32'(err), 32'd1);
    checkOutput({tag, "_busy"}, 32'(busy), 32'd0);
    checkOutput({tag, "_req"}, 32'(imemReq), 32'd0);
    checkOutput({tag, "_pcHeld"}, pc, mPc);
    checkOutput({tag, "_instret"}, instret, expInstret());
  endtask

  // Drives one instruction from the first FETCH cycle to retirement or halt.
  task automatic applyStimulus(input logic [31:0] instr, input int waitCycles, input string tag);
    int          cycles;
    int          reqCycles;
    logic [31:0] op, rd, fn, rs1, rs2, imm, bf;
    logic        legal;
    exuResp_t    r;
    cycles    = 0;
    reqCycles = 0;
    checkOutput({tag, "_addr"}, imemAddr, mPc);
    for (int w = 0; w <= waitCycles; w++) begin
      if (imemReq === 1'b1) reqCycles++;
      imemAck   = (w == waitCycles);
      imemRdata = imemAck ? instr : $urandom();
      tick();
      cycles++;
    end
    imemAck   = 1'b0;
    imemRdata = $urandom();
    checkOutput({tag, "_reqCycles"}, 32'(reqCycles), 32'(waitCycles + 1));

    op  = instr & 32'h7f;
    rd  = (instr >> 7) & 32'h1f;
    fn  = (instr >> 12) & 32'hf;
    rs1 = (instr >> 16) & 32'h1f;
    rs2 = (instr >> 21) & 32'h1f;
    case (op)
      32'd1: begin
        legal = (fn inside {0, 1, 4, 5, 6, 7, 8, 13});
        imm   = 32'd0;
      end
      32'd3: begin
        legal = (fn inside {0, 1, 4, 5, 6, 7});
        imm   = 32'($signed(instr) >>> 21);
      end
      32'd7: begin
        legal = 1'b1;
        imm   = 32'($signed(instr) >>> 12);
      end
      32'd15: begin
        legal = (fn inside {0, 1, 3, 4, 5, 6, 7});
        bf    = ((instr >> 26) << 5) | ((instr >> 7) & 32'h1f);
        imm   = (bf >= 32'd1024) ? bf - 32'd2048 : bf;
      end
      default: begin
        legal = 1'b0;
        imm   = 32'd0;
      end
    endcase

    checkOutput({tag, "_decReq"}, 32'(imemReq), 32'd0);
    checkOutput({tag, "_decBusy"}, 32'(busy), 32'd1);
    tick();
    cycles++;
    if (!legal) begin
      checkHalt({tag, "_illegal"});
      return;
    end

    checkOutput({tag, "_exuOp"}, 32'(exuOpcode), op);
    checkOutput({tag, "_exuFn"}, 32'(exuFunct), fn);
    checkOutput({tag, "_exuImm"}, exuImm, imm);
    checkOutput({tag, "_exuRs1"}, exuRs1Data, mRegs[rs1[4:0]]);
    checkOutput({tag, "_exuRs2"}, exuRs2Data, mRegs[rs2[4:0]]);
    r = exuBehave(op[6:0], fn[3:0], imm, mRegs[rs1[4:0]], mRegs[rs2[4:0]]);
    tick();
    cycles++;
    if (r.err) begin
      checkHalt({tag, "_trap"});
      return;
    end

    checkOutput({tag, "_wbPc"}, pc, mPc);
    tick();
    cycles++;
    mPc = mPc + (r.pcUpd ? r.result : 32'd4);
    if (r.we && (rd != 32'd0)) mRegs[rd[4:0]] = r.result;
    mInstret = mInstret + 32'd1;
    checkOutput({tag, "_pc"}, pc, mPc);
    checkOutput({tag, "_instret"}, instret, expInstret());
    checkOutput({tag, "_cycles"}, 32'(cycles), 32'(4 + waitCycles));
    checkOutput({tag, "_nextReq"}, 32'(imemReq), 32'd1);
  endtask

  function automatic logic [31:0] randInstr();
    logic [31:0] w;
    w = $urandom();
    case ($urandom_range(0, 3))
      0: begin
        w[6:0]   = 7'd1;
        w[15:12] = 4'(rFns[$urandom_range(0, 7)]);
      end
      1: begin
        w[6:0]   = 7'd3;
        w[15:12] = 4'(iFns[$urandom_range(0, 5)]);
      end
      2: w[6:0] = 7'd7;
      default: begin
        w[6:0]   = 7'd15;
        w[15:12] = 4'(bFns[$urandom_range(0, 5)]);
      end
    endcase
    return w;
  endfunction

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    imemAck   = 1'b0;
    imemRdata = 32'd0;
    resetModel();
    tick();
    tick();
    checkResetState("reset");
    rst = 1'b0;
    tick();

    // First fetch request appears the cycle after start is sampled.
    start = 1'b1;
    checkOutput("idleReq", 32'(imemReq), 32'd0);
    tick();
    start = 1'b0;
    checkOutput("startReq", 32'(imemReq), 32'd1);

    applyStimulus(32'h00A00083, 0, "addi");
    checkOutput("addiPc", pc, 32'd4);
    checkOutput("addiX1", dut.u_regfile.r_regs[1], 32'd5);
    applyStimulus(32'h00210101, 0, "add");
    checkOutput("addPc", pc, 32'd8);
    checkOutput("addX2", dut.u_regfile.r_regs[2], 32'd10);
    applyStimulus(32'h0021080F, 0, "beqTaken");
    checkOutput("beqTakenPc", pc, 32'd24);
    applyStimulus(32'h0041080F, 0, "beqNot");
    checkOutput("beqNotPc", pc, 32'd28);
    applyStimulus(32'h00A00083, 3, "waitAck");
    applyStimulus(32'h12345007, 1, "movX0");
    applyStimulus(32'h00000181, 0, "readX0");
    checkOutput("x3Zero", dut.u_regfile.r_regs[3], 32'd0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus(randInstr(), int'($urandom_range(0, 3)), $sformatf("rand%0d", i));
    end
    for (int i = 1; i < 32; i++) begin
      checkOutput($sformatf("reg%0d", i), dut.u_regfile.r_regs[i], mRegs[i]);
    end

    applyStimulus(32'h00000000, 0, "illegal");
    start = 1'b1;
    tick();
    tick();
    tick();
    start = 1'b0;
    checkHalt("startIgnored");

    // Reset while a fetch is stalled waiting for imem_ack.
    rst = 1'b1;
    #1;
    checkResetState("haltReset");
    tick();
    rst = 1'b0;
    resetModel();
    tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    checkOutput("midFetchReq", 32'(imemReq), 32'd1);
    tick();
    tick();
    rst = 1'b1;
    #1;
    checkOutput("asyncReqDrop", 32'(imemReq), 32'd0);
    checkResetState("midFetch");
    tick();
    rst = 1'b0;
    tick();
    checkOutput("idleAfterReset", 32'(imemReq), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    applyStimulus(32'h00A00083, 2, "restart");
    applyStimulus(32'h0000300F, 0, "exuTrap");

    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
